bram_port_arb: RTL and testbench

Two-master arbiter that shares one BRAM port (the 32-bit address / 32-bit data / 4-bit byte-write-enable port driven by `pe_con`) between two requesters, e.g. two PE controllers or a PE controller plus a loader/unloader. Owner selection is round-robin with optional bus locking. A hold limit bounds how long an unlocked owner may starve the other master. Read data returns with the BRAM's fixed latency and is tagged back to the master that issued the read, even across ownership changes.

---
 rtl/bram_port_arb.sv | 197 +++++++++++++++++++
 tb/tb_bram_port_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arb.sv
// bram_port_arb
// Shares one BRAM port between two masters. Ownership is round-robin with
// optional per-master locking. An unlocked owner is forced off after
// MAX_HOLD consecutive owned cycles if the other master is waiting. Reads
// are tracked through a RD_LATENCY-deep {valid, id} pipe, so each read's
// data is flagged to the master that issued it, even if ownership changes
// in the meantime.
//
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   mN_req / mN_lock       master N request / no-preemption request
//   mN_gnt                 master N owns the port (registered)
//   mN_addr/wrdata/we      master N access; we == 0 means read
//   mN_rddata / mN_rvalid  broadcast read data / read data valid for N
//   BRAM_*                 BRAM port (CLK, EN, ADDR, WRDATA, WE, RDDATA)
//   busy                   port owned or reads still in flight
module bram_port_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD   = 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    m0_req,
  input  logic                    m0_lock,
  output logic                    m0_gnt,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wrdata,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  output logic [DATA_WIDTH-1:0]   m0_rddata,
  output logic                    m0_rvalid,
  input  logic                    m1_req,
  input  logic                    m1_lock,
  output logic                    m1_gnt,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wrdata,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  output logic [DATA_WIDTH-1:0]   m1_rddata,
  output logic                    m1_rvalid,
  output logic                    BRAM_CLK,
  output logic                    BRAM_EN,
  output logic [ADDR_WIDTH-1:0]   BRAM_ADDR,
  output logic [DATA_WIDTH-1:0]   BRAM_WRDATA,
  output logic [DATA_WIDTH/8-1:0] BRAM_WE,
  input  logic [DATA_WIDTH-1:0]   BRAM_RDDATA,
  output logic                    busy
);

  localparam int WE_WIDTH = DATA_WIDTH / 8;
  localparam int HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  last;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_id;
  logic                  issue_rd;
  logic                  issue_id;

  assign BRAM_CLK  = aclk;
  assign m0_rddata = BRAM_RDDATA;
  assign m1_rddata = BRAM_RDDATA;

  // State, grant, round-robin pointer and hold counter registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      last     <= 1'b1;
      hold_cnt <= {HOLD_W{1'b0}};
    end else begin
      state  <= next_state;
      m0_gnt <= (next_state == OWN0);
      m1_gnt <= (next_state == OWN1);
      if (next_state == OWN0) begin
        last <= 1'b0;
      end else if (next_state == OWN1) begin
        last <= 1'b1;
      end else begin
        last <= last;
      end
      // Count restarts whenever ownership changes hands or the port idles.
      if ((next_state != state) || (next_state == IDLE)) begin
        hold_cnt <= {HOLD_W{1'b0}};
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
      end else begin
        hold_cnt <= hold_cnt;
      end
    end
  end

  // Next-state arbitration: round-robin on ties, forced rotation at hold limit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          next_state = last ? OWN0 : OWN1;
        end else if (m0_req) begin
          next_state = OWN0;
        end else if (m1_req) begin
          next_state = OWN1;
        end else begin
          next_state = IDLE;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          next_state = m1_req ? OWN1 : IDLE;
        end else if (!m0_lock && m1_req && (hold_cnt == HOLD_LAST)) begin
          next_state = OWN1;
        end else begin
          next_state = OWN0;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          next_state = m0_req ? OWN0 : IDLE;
        end else if (!m1_lock && m0_req && (hold_cnt == HOLD_LAST)) begin
          next_state = OWN0;
        end else begin
          next_state = OWN1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // BRAM port mux: the owner's access goes out only while it still requests.
  always_comb begin
    BRAM_EN     = 1'b0;
    BRAM_ADDR   = {ADDR_WIDTH{1'b0}};
    BRAM_WRDATA = {DATA_WIDTH{1'b0}};
    BRAM_WE     = {WE_WIDTH{1'b0}};
    issue_id    = 1'b0;
    case (state)
      OWN0: begin
        if (m0_req) begin
          BRAM_EN     = 1'b1;
          BRAM_ADDR   = m0_addr;
          BRAM_WRDATA = m0_wrdata;
          BRAM_WE     = m0_we;
        end else begin
          BRAM_EN     = 1'b0;
        end
      end
      OWN1: begin
        issue_id = 1'b1;
        if (m1_req) begin
          BRAM_EN     = 1'b1;
          BRAM_ADDR   = m1_addr;
          BRAM_WRDATA = m1_wrdata;
          BRAM_WE     = m1_we;
        end else begin
          BRAM_EN     = 1'b0;
        end
      end
      default: begin
        BRAM_EN = 1'b0;
      end
    endcase
    issue_rd = BRAM_EN && (BRAM_WE == {WE_WIDTH{1'b0}});
  end

  // Read-tracking pipe; its tail lines up with valid BRAM_RDDATA.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pipe_valid <= {RD_LATENCY{1'b0}};
      pipe_id    <= {RD_LATENCY{1'b0}};
    end else begin
      pipe_valid[0] <= issue_rd;
      pipe_id[0]    <= issue_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign m0_rvalid = pipe_valid[RD_LATENCY-1] && !pipe_id[RD_LATENCY-1];
  assign m1_rvalid = pipe_valid[RD_LATENCY-1] &&  pipe_id[RD_LATENCY-1];
  assign busy      = (state != IDLE) || (|pipe_valid);

endmodule

// File: tb/tb_bram_port_arb.sv
// Directed table-driven bench for bram_port_arb. Two instances share one set
// of inputs: u_lat1 (RD_LATENCY=1) is checked against the per-cycle table and
// u_lat2 (RD_LATENCY=2) against the reset-mid-read sequence. Both instances
// use MAX_HOLD=4.
module tb_bram_port_arb;

  logic        aclk = 1'b0;
  logic        areset;
  logic        load;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wrdata, m1_addr, m1_wrdata;
  logic [3:0]  m0_we, m1_we;

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_clk, bram_en, busy;
  logic [31:0] m0_rddata, m1_rddata, bram_addr, bram_wrdata, rd1;
  logic [3:0]  bram_we;

  logic        m0_gnt2, m1_gnt2, m0_rvalid2, m1_rvalid2, bram_clk2, bram_en2, busy2;
  logic [31:0] m0_rddata2, m1_rddata2, bram_addr2, bram_wrdata2, rd2a, rd2;
  logic [3:0]  bram_we2;

  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic        r0, l0, w0;
    logic [7:0]  a0;
    logic        r1, w1;
    logic [7:0]  a1;
    logic [31:0] wd;
    logic        g0, g1, en;
    logic [7:0]  ea;
    logic        ewe, v0, v1;
    logic [31:0] ed;
    logic        bsy;
  } vec_t;

  vec_t tbl [$];

  always #5 aclk = ~aclk;

  bram_port_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1), .MAX_HOLD(4)) u_lat1 (
    .aclk(aclk), .areset(areset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_addr(m0_addr),
    .m0_wrdata(m0_wrdata), .m0_we(m0_we), .m0_rddata(m0_rddata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_addr(m1_addr),
    .m1_wrdata(m1_wrdata), .m1_we(m1_we), .m1_rddata(m1_rddata), .m1_rvalid(m1_rvalid),
    .BRAM_CLK(bram_clk), .BRAM_EN(bram_en), .BRAM_ADDR(bram_addr),
    .BRAM_WRDATA(bram_wrdata), .BRAM_WE(bram_we), .BRAM_RDDATA(rd1), .busy(busy)
  );

  bram_port_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(2), .MAX_HOLD(4)) u_lat2 (
    .aclk(aclk), .areset(areset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_gnt(m0_gnt2), .m0_addr(m0_addr),
    .m0_wrdata(m0_wrdata), .m0_we(m0_we), .m0_rddata(m0_rddata2), .m0_rvalid(m0_rvalid2),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_gnt(m1_gnt2), .m1_addr(m1_addr),
    .m1_wrdata(m1_wrdata), .m1_we(m1_we), .m1_rddata(m1_rddata2), .m1_rvalid(m1_rvalid2),
    .BRAM_CLK(bram_clk2), .BRAM_EN(bram_en2), .BRAM_ADDR(bram_addr2),
    .BRAM_WRDATA(bram_wrdata2), .BRAM_WE(bram_we2), .BRAM_RDDATA(rd2), .busy(busy2)
  );

  // BRAM model: byte writes from u_lat1, 1-cycle read for u_lat1, 2-cycle for u_lat2.
  always @(posedge aclk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
      mem[8'h10] <= 32'hDEAD_BEEF;
    end else if (bram_en && bram_we != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[7:0]][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end
    if (bram_en && bram_we == 4'h0) rd1 <= mem[bram_addr[7:0]];
    rd2a <= (bram_en2 && bram_we2 == 4'h0) ? mem[bram_addr2[7:0]] : 32'h0;
    rd2  <= rd2a;
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r0, l0, w0, input logic [7:0] a0,
                     input logic r1, w1, input logic [7:0] a1, input logic [31:0] wd,
                     input logic g0, g1, en, input logic [7:0] ea, input logic ewe,
                     input logic v0, v1, input logic [31:0] ed, input logic bsy);
    vec_t v;
    v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.wd = wd;
    v.g0 = g0; v.g1 = g1; v.en = en; v.ea = ea; v.ewe = ewe;
    v.v0 = v0; v.v1 = v1; v.ed = ed; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  task automatic idle_row();
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0, 0,0,0,8'h00,0, 0,0,32'h0, 0);
  endtask

  initial begin
    areset = 1'b1; load = 1'b1;
    m0_req = 1'b0; m0_lock = 1'b0; m0_addr = 32'h0; m0_wrdata = 32'h0; m0_we = 4'h0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_addr = 32'h0; m1_wrdata = 32'h0; m1_we = 4'h0;

    // Tie after reset goes to m0; m0 releases after 3 accesses, m1 follows at once.
    add(1,0,0,8'h20, 1,0,8'h30, 32'h0, 0,0,0,8'h00,0, 0,0,32'h0,         0);
    add(1,0,0,8'h20, 1,0,8'h30, 32'h0, 1,0,1,8'h20,0, 0,0,32'h0,         1);
    add(1,0,0,8'h20, 1,0,8'h30, 32'h0, 1,0,1,8'h20,0, 1,0,32'hA000_0020, 1);
    add(1,0,0,8'h20, 1,0,8'h30, 32'h0, 1,0,1,8'h20,0, 1,0,32'hA000_0020, 1);
    add(0,0,0,8'h20, 1,0,8'h30, 32'h0, 1,0,0,8'h00,0, 1,0,32'hA000_0020, 1);
    add(0,0,0,8'h00, 1,0,8'h30, 32'h0, 0,1,1,8'h30,0, 0,0,32'h0,         1);
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0, 0,1,0,8'h00,0, 0,1,32'hA000_0030, 1);
    // Repeat tie: last owner was m1, so m0 wins.
    add(1,0,0,8'h20, 1,0,8'h30, 32'h0, 0,0,0,8'h00,0, 0,0,32'h0,         0);
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0, 1,0,0,8'h00,0, 0,0,32'h0,         1);
    idle_row();
    // Single read of 0x10.
    add(1,0,0,8'h10, 0,0,8'h00, 32'h0, 0,0,0,8'h00,0, 0,0,32'h0,         0);
    add(1,0,0,8'h10, 0,0,8'h00, 32'h0, 1,0,1,8'h10,0, 0,0,32'h0,         1);
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0, 1,0,0,8'h00,0, 1,0,32'hDEAD_BEEF, 1);
    idle_row();
    // m1 write then read-back of addr 4.
    add(0,0,0,8'h00, 1,1,8'h04, 32'h1234_5678, 0,0,0,8'h00,0, 0,0,32'h0, 0);
    add(0,0,0,8'h00, 1,1,8'h04, 32'h1234_5678, 0,1,1,8'h04,1, 0,0,32'h0, 1);
    add(0,0,0,8'h00, 1,0,8'h04, 32'h0,         0,1,1,8'h04,0, 0,0,32'h0, 1);
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0,         0,1,0,8'h00,0, 0,1,32'h1234_5678, 1);
    idle_row();
    // Forced rotation after 4 accesses; m0's last read returns under m1 ownership.
    add(1,0,0,8'h40, 0,0,8'h00, 32'h0, 0,0,0,8'h00,0, 0,0,32'h0,         0);
    add(1,0,0,8'h40, 0,0,8'h00, 32'h0, 1,0,1,8'h40,0, 0,0,32'h0,         1);
    for (int i = 0; i < 3; i++)
      add(1,0,0,8'h40, 1,0,8'h50, 32'h0, 1,0,1,8'h40,0, 1,0,32'hA000_0040, 1);
    add(1,0,0,8'h40, 1,0,8'h50, 32'h0, 0,1,1,8'h50,0, 1,0,32'hA000_0040, 1);
    add(1,0,0,8'h40, 0,0,8'h00, 32'h0, 0,1,0,8'h00,0, 0,1,32'hA000_0050, 1);
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0, 1,0,0,8'h00,0, 0,0,32'h0,         1);
    idle_row();
    // Lock: m0 keeps the port for 10 accesses despite m1 waiting.
    add(1,1,0,8'h60, 0,0,8'h00, 32'h0, 0,0,0,8'h00,0, 0,0,32'h0,         0);
    add(1,1,0,8'h60, 0,0,8'h00, 32'h0, 1,0,1,8'h60,0, 0,0,32'h0,         1);
    for (int i = 0; i < 9; i++)
      add(1,1,0,8'h60, 1,0,8'h70, 32'h0, 1,0,1,8'h60,0, 1,0,32'hA000_0060, 1);
    add(0,0,0,8'h00, 1,0,8'h70, 32'h0, 1,0,0,8'h00,0, 1,0,32'hA000_0060, 1);
    add(0,0,0,8'h00, 1,0,8'h70, 32'h0, 0,1,1,8'h70,0, 0,0,32'h0,         1);
    add(0,0,0,8'h00, 0,0,8'h00, 32'h0, 0,1,0,8'h00,0, 0,1,32'hA000_0070, 1);
    idle_row();

    // Reset state.
    @(negedge aclk);
    chk("rst_gnt0", -1, m0_gnt, 1'b0);
    chk("rst_gnt1", -1, m1_gnt, 1'b0);
    chk("rst_en", -1, bram_en, 1'b0);
    chk("rst_we", -1, bram_we, 4'h0);
    chk("rst_busy", -1, busy, 1'b0);
    chk("rst_rvalid", -1, {m0_rvalid, m1_rvalid}, 2'b00);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0; load = 1'b0;

    foreach (tbl[i]) begin
      @(posedge aclk);
      #1;
      m0_req = tbl[i].r0; m0_lock = tbl[i].l0; m0_addr = {24'h0, tbl[i].a0};
      m0_we = tbl[i].w0 ? 4'hF : 4'h0; m0_wrdata = tbl[i].wd;
      m1_req = tbl[i].r1; m1_addr = {24'h0, tbl[i].a1};
      m1_we = tbl[i].w1 ? 4'hF : 4'h0; m1_wrdata = tbl[i].wd;
      @(negedge aclk);
      chk("m0_gnt", i, m0_gnt, tbl[i].g0);
      chk("m1_gnt", i, m1_gnt, tbl[i].g1);
      chk("bram_en", i, bram_en, tbl[i].en);
      chk("bram_addr", i, bram_addr, {24'h0, tbl[i].ea});
      chk("bram_we", i, bram_we, tbl[i].ewe ? 4'hF : 4'h0);
      chk("bram_wrdata", i, bram_wrdata, tbl[i].en ? tbl[i].wd : 32'h0);
      chk("m0_rvalid", i, m0_rvalid, tbl[i].v0);
      chk("m1_rvalid", i, m1_rvalid, tbl[i].v1);
      chk("busy", i, busy, tbl[i].bsy);
      if (tbl[i].v0) chk("m0_rddata", i, m0_rddata, tbl[i].ed);
      if (tbl[i].v1) chk("m1_rddata", i, m1_rddata, tbl[i].ed);
    end

    // Reset one cycle after a read issue on the 2-cycle-latency instance.
    @(posedge aclk); #1 m0_req = 1'b1; m0_addr = 32'h10; m0_lock = 1'b0;
    m1_req = 1'b0; m0_we = 4'h0; m1_we = 4'h0; m0_wrdata = 32'h0; m1_wrdata = 32'h0;
    @(posedge aclk); @(negedge aclk);
    chk("rr_gnt_pre", 100, m0_gnt2, 1'b1);
    chk("rr_en_pre", 100, bram_en2, 1'b1);
    @(posedge aclk); #1 m0_req = 1'b0; areset = 1'b1;
    #1;
    chk("rr_gnt0", 101, m0_gnt2, 1'b0);
    chk("rr_en", 101, bram_en2, 1'b0);
    chk("rr_busy", 101, busy2, 1'b0);
    chk("rr_rvalid2", 101, m0_rvalid2, 1'b0);
    chk("rr_rvalid1", 101, m0_rvalid, 1'b0);
    chk("rr_gnt0_l1", 101, m0_gnt, 1'b0);
    @(negedge aclk);
    chk("rr_rvalid_hold", 102, {m0_rvalid2, m1_rvalid2}, 2'b00);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    chk("rr_rvalid_post", 103, {m0_rvalid2, m1_rvalid2}, 2'b00);
    chk("rr_busy_post", 103, busy2, 1'b0);
    // Tie after reset: m0 first; its read returns two cycles after issue.
    @(posedge aclk); #1 m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h10; m1_addr = 32'h30;
    @(posedge aclk); #1 m1_req = 1'b0;
    @(negedge aclk);
    chk("rr_tie_gnt0", 104, m0_gnt2, 1'b1);
    chk("rr_tie_gnt1", 104, m1_gnt2, 1'b0);
    chk("rr_tie_en", 104, bram_en2, 1'b1);
    chk("rr_tie_addr", 104, bram_addr2, 32'h10);
    @(posedge aclk); #1 m0_req = 1'b0;
    @(negedge aclk);
    chk("rr_lat_early", 105, m0_rvalid2, 1'b0);
    @(posedge aclk); @(negedge aclk);
    chk("rr_lat_valid", 106, m0_rvalid2, 1'b1);
    chk("rr_lat_other", 106, m1_rvalid2, 1'b0);
    chk("rr_lat_data", 106, m0_rddata2, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
